// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver with a scancode FIFO, sticky error flags, frame watchdog
// and an AXI4-Lite register interface. kbd_intr is a registered level.
module ps2_kbd_fifo #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYC    = 100000
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        kbd_intr,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]                  S_AXI_awprot,
  input  logic                        S_AXI_awvalid,
  output logic                        S_AXI_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                        S_AXI_wvalid,
  output logic                        S_AXI_wready,
  output logic [1:0]                  S_AXI_bresp,
  output logic                        S_AXI_bvalid,
  input  logic                        S_AXI_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]                  S_AXI_arprot,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic [1:0] w_raw, w_filt;
  logic       r_clk_prev, w_fall, w_bit;
  rx_state_t  r_state;
  logic [7:0] r_shift, r_push_byte;
  logic [2:0] r_bitcnt;
  logic       r_par, r_push, r_perr_set, r_ferr_set;
  logic [TW-1:0] r_wdog;
  logic       r_awready, r_bvalid, r_arready, r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata, w_rd_val;
  logic       r_rx_en, r_irq_en, r_ovf, r_perr, r_ferr, r_intr;
  logic [8:0] r_level, w_level, w_count9;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic       w_wr_hs, w_rd_hs, w_wr_stat, w_wr_ctrl, w_wr_irq, w_flush;
  logic       w_full, w_empty, w_push_ok, w_ovf_set, w_pop;
  logic [2:0] w_clr;
  logic       w_unused;

  assign w_raw = {ps2_data, ps2_clk};

  // Per-line synchroniser plus stability filter; lines idle high.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      logic [1:0]    r_sync;
      logic          r_filt;
      logic [FW-1:0] r_cnt;
      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          r_sync <= 2'b11;
          r_filt <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= r_sync[1];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
      assign w_filt[gi] = r_filt;
    end
  endgenerate

  assign w_fall = r_clk_prev & ~w_filt[0];
  assign w_bit  = w_filt[1];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_clk_prev  <= 1'b1;
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_par       <= 1'b0;
      r_wdog      <= '0;
      r_push      <= 1'b0;
      r_push_byte <= '0;
      r_perr_set  <= 1'b0;
      r_ferr_set  <= 1'b0;
    end else begin
      r_clk_prev <= w_filt[0];
      r_push     <= 1'b0;
      r_perr_set <= 1'b0;
      r_ferr_set <= 1'b0;
      if (!r_rx_en) begin
        r_state <= S_IDLE;
        r_wdog  <= '0;
      end else if (w_fall) begin
        r_wdog <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_ferr_set <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_bit;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_bit) begin
              r_ferr_set <= 1'b1;
            end else if (^{r_shift, r_par}) begin
              r_push      <= 1'b1;
              r_push_byte <= r_shift;
            end else begin
              r_perr_set <= 1'b1;
            end
          end
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_wdog == TW'(TIMEOUT_CYC - 1)) begin
          r_state    <= S_IDLE;
          r_ferr_set <= 1'b1;
          r_wdog     <= '0;
        end else begin
          r_wdog <= r_wdog + 1'b1;
        end
      end else begin
        r_wdog <= '0;
      end
    end
  end

  assign w_wr_hs   = r_awready & S_AXI_awvalid & S_AXI_wvalid;
  assign w_rd_hs   = r_arready & S_AXI_arvalid;
  assign w_wr_stat = w_wr_hs & (S_AXI_awaddr[3:2] == 2'd1);
  assign w_wr_ctrl = w_wr_hs & (S_AXI_awaddr[3:2] == 2'd2);
  assign w_wr_irq  = w_wr_hs & (S_AXI_awaddr[3:2] == 2'd3);
  assign w_flush   = w_wr_ctrl & S_AXI_wstrb[0] & S_AXI_wdata[2];
  assign w_clr     = (w_wr_stat & S_AXI_wstrb[0]) ? S_AXI_wdata[4:2] : 3'b000;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // Flush wins over any push or pop landing on the same edge.
  assign w_push_ok = r_push & ~w_full & ~w_flush;
  assign w_ovf_set = r_push & w_full & ~w_flush;
  assign w_pop     = w_rd_hs & (S_AXI_araddr[3:2] == 2'd0) & ~w_empty & ~w_flush;
  assign w_count9  = 9'(r_count);
  assign w_level   = (r_level == 9'd0) ? 9'd1 : r_level;

  always_comb begin
    w_rd_val = '0;
    case (S_AXI_araddr[3:2])
      2'd0: if (!w_empty) w_rd_val = {23'd0, 1'b1, r_mem[r_rptr]};
      2'd1: w_rd_val = {15'd0, w_count9, 3'd0, r_ferr, r_perr, r_ovf, w_full, w_empty};
      2'd2: w_rd_val = {30'd0, r_irq_en, r_rx_en};
      default: w_rd_val = {23'd0, r_level};
    endcase
  end

  always_ff @(posedge aclk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_push_byte;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rx_en   <= 1'b0;
      r_irq_en  <= 1'b0;
      r_level   <= 9'd1;
      r_ovf     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_intr    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_awready <= S_AXI_awvalid & S_AXI_wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_hs) r_bvalid <= 1'b1;
      else if (S_AXI_bready) r_bvalid <= 1'b0;
      r_arready <= S_AXI_arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (S_AXI_rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_wr_ctrl & S_AXI_wstrb[0]) begin
        r_rx_en  <= S_AXI_wdata[0];
        r_irq_en <= S_AXI_wdata[1];
      end
      if (w_wr_irq & S_AXI_wstrb[0]) r_level[7:0] <= S_AXI_wdata[7:0];
      if (w_wr_irq & S_AXI_wstrb[1]) r_level[8]   <= S_AXI_wdata[8];
      // A set event on the clearing edge keeps the flag set.
      r_ovf  <= (r_ovf  & ~w_clr[0]) | w_ovf_set;
      r_perr <= (r_perr & ~w_clr[1]) | r_perr_set;
      r_ferr <= (r_ferr & ~w_clr[2]) | r_ferr_set;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + 1'b1;
        if (w_pop)     r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      end
      r_intr <= r_irq_en & ((w_count9 >= w_level) | r_ovf | r_perr | r_ferr);
    end
  end

  assign kbd_intr      = r_intr;
  assign S_AXI_awready = r_awready;
  assign S_AXI_wready  = r_awready;
  assign S_AXI_bvalid  = r_bvalid;
  assign S_AXI_bresp   = 2'b00;
  assign S_AXI_arready = r_arready;
  assign S_AXI_rvalid  = r_rvalid;
  assign S_AXI_rdata   = r_rdata;
  assign S_AXI_rresp   = 2'b00;

  assign w_unused = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr, S_AXI_araddr,
                      S_AXI_wdata, S_AXI_wstrb};
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: frame table, scoreboard of expected scancodes and
// hand-written sequences for reset, overflow, watchdog, push/pop collision and IRQ level.
`timescale 1ns/1ps
module tb_ps2_kbd_fifo;
  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int TMO   = 300;
  localparam int HALF  = 16;
  localparam logic [15:0] A_DATA = 16'h0, A_STAT = 16'h4, A_CTRL = 16'h8, A_IRQ = 16'hC;

  logic        aclk = 1'b0, areset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic        kbd_intr;
  logic [15:0] S_AXI_awaddr = '0, S_AXI_araddr = '0;
  logic [2:0]  S_AXI_awprot = '0, S_AXI_arprot = '0;
  logic        S_AXI_awvalid = 1'b0, S_AXI_wvalid = 1'b0, S_AXI_bready = 1'b0;
  logic        S_AXI_arvalid = 1'b0, S_AXI_rready = 1'b0;
  logic [31:0] S_AXI_wdata = '0;
  logic [3:0]  S_AXI_wstrb = '0;
  logic        S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_arready, S_AXI_rvalid;
  logic [1:0]  S_AXI_bresp, S_AXI_rresp;
  logic [31:0] S_AXI_rdata;

  ps2_kbd_fifo #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .FIFO_DEPTH(DEPTH),
    .FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)
  ) dut (
    .aclk(aclk), .areset(areset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kbd_intr(kbd_intr),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awvalid(S_AXI_awvalid),
    .S_AXI_awready(S_AXI_awready), .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready), .S_AXI_bresp(S_AXI_bresp),
    .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready), .S_AXI_araddr(S_AXI_araddr),
    .S_AXI_arprot(S_AXI_arprot), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
    .S_AXI_rready(S_AXI_rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    bit          bad_stop;
    logic [31:0] exp_status;
    logic        exp_intr;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  bit         tb_rx_en = 1'b0;
  logic [8:0] sb_q[$];
  vec_t       vecs[6];
  logic [31:0] d;
  logic [7:0]  a_code, b_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake timeout, got no response, expected one within 50 cycles", name);
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data);
    int n;
    #1;
    S_AXI_awaddr = addr; S_AXI_wdata = data; S_AXI_wstrb = 4'hF;
    S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!(S_AXI_awready && S_AXI_wready) && n < 50);
    if (!(S_AXI_awready && S_AXI_wready)) timeout_fail("aw_w_ready");
    @(posedge aclk); #1;
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    n = 0;
    while (!S_AXI_bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!S_AXI_bvalid) timeout_fail("bvalid");
    else check($sformatf("bresp@%0h", addr), 32'(S_AXI_bresp), 32'h0);
    S_AXI_bready = 1'b1;
    @(posedge aclk); #1;
    S_AXI_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
    int n;
    #1;
    S_AXI_araddr = addr; S_AXI_arvalid = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!S_AXI_arready && n < 50);
    if (!S_AXI_arready) timeout_fail("arready");
    @(posedge aclk); #1;
    S_AXI_arvalid = 1'b0;
    n = 0;
    while (!S_AXI_rvalid && n < 50) begin @(negedge aclk); n++; end
    if (!S_AXI_rvalid) timeout_fail("rvalid");
    data = S_AXI_rdata;
    S_AXI_rready = 1'b1;
    @(posedge aclk); #1;
    S_AXI_rready = 1'b0;
  endtask

  // DATA read compared against the scoreboard head (0 when nothing is expected).
  task automatic read_data(input string name);
    logic [31:0] v;
    logic [31:0] exp;
    exp = (sb_q.size() != 0) ? 32'(sb_q.pop_front()) : 32'h0;
    axi_read(A_DATA, v);
    check(name, v, exp);
  endtask

  task automatic read_check(input string name, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(addr, v);
    check(name, v, exp);
  endtask

  task automatic intr_check(input string name, input logic exp);
    repeat (2) @(negedge aclk);
    check(name, 32'(kbd_intr), 32'(exp));
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = (~^code) ^ bad_par;
    bits = {~bad_stop, par, code, 1'b0};
    if (nbits == 11 && !bad_par && !bad_stop && tb_rx_en && sb_q.size() < DEPTH)
      sb_q.push_back({1'b1, code});
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge aclk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge aclk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (4) @(posedge aclk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish, expected finish within 2 ms");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 32'h100, 1'b1};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 32'h009, 1'b1};
    vecs[2] = '{8'h33, 1'b0, 1'b1, 32'h011, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 32'h100, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 32'h100, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 32'h009, 1'b1};

    // Reset state
    repeat (4) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("rst_outputs", 32'({S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bresp,
          S_AXI_arready, S_AXI_rvalid, S_AXI_rresp, kbd_intr}), 32'h0);
    check("rst_rdata", S_AXI_rdata, 32'h0);
    read_check("rst_status", A_STAT, 32'h001);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_irq_level", A_IRQ, 32'h1);

    // Reset in the middle of a frame
    axi_write(A_CTRL, 32'h3); tb_rx_en = 1'b1;
    send_frame(8'h12, 1'b0, 1'b0, 11);
    read_check("pre_rst_status", A_STAT, 32'h100);
    send_frame(8'h34, 1'b0, 1'b0, 5);
    @(posedge aclk); #1 areset = 1'b1;
    sb_q.delete(); tb_rx_en = 1'b0;
    @(negedge aclk);
    check("midrst_outputs", 32'({S_AXI_awready, S_AXI_wready, S_AXI_bvalid, S_AXI_bresp,
          S_AXI_arready, S_AXI_rvalid, S_AXI_rresp, kbd_intr}), 32'h0);
    check("midrst_rdata", S_AXI_rdata, 32'h0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    read_check("midrst_status", A_STAT, 32'h001);
    axi_write(A_CTRL, 32'h1); tb_rx_en = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    read_data("midrst_next_frame");

    // Three frames, IRQ and DATA pops
    axi_write(A_CTRL, 32'h3);
    intr_check("intr_idle", 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    intr_check("intr_first_push", 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    read_check("three_status", A_STAT, 32'h300);
    for (int i = 0; i < 4; i++) read_data($sformatf("three_data%0d", i));
    intr_check("intr_drained", 1'b0);

    // Frame table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11);
      read_check($sformatf("vec%0d_status", i), A_STAT, vecs[i].exp_status);
      intr_check($sformatf("vec%0d_intr", i), vecs[i].exp_intr);
      read_data($sformatf("vec%0d_data", i));
      axi_write(A_STAT, 32'h1C);
      read_check($sformatf("vec%0d_cleared", i), A_STAT, 32'h001);
      intr_check($sformatf("vec%0d_intr_clr", i), 1'b0);
    end

    // Overflow
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 11);
    read_check("ovf_status", A_STAT, 32'h406);
    for (int i = 0; i < 5; i++) read_data($sformatf("ovf_data%0d", i));
    axi_write(A_STAT, 32'h04);
    read_check("ovf_cleared", A_STAT, 32'h001);

    // Watchdog
    send_frame(8'h77, 1'b0, 1'b0, 4);
    repeat (TMO - 60) @(posedge aclk);
    read_check("wdog_before", A_STAT, 32'h001);
    repeat (80) @(posedge aclk);
    read_check("wdog_after", A_STAT, 32'h011);
    axi_write(A_STAT, 32'h10);
    send_frame(8'h29, 1'b0, 1'b0, 11);
    read_check("wdog_next_status", A_STAT, 32'h100);
    read_data("wdog_next_data");

    // Push colliding with a DATA pop at count=1, swept across the push edge
    for (int k = 0; k < 16; k++) begin
      a_code = 8'h40 + 8'(k);
      b_code = 8'h80 + 8'(k);
      send_frame(a_code, 1'b0, 1'b0, 11);
      fork
        send_frame(b_code, 1'b0, 1'b0, 11);
        begin
          repeat (21 * HALF + k) @(posedge aclk);
          read_data($sformatf("pp%0d_first", k));
        end
      join
      read_check($sformatf("pp%0d_status", k), A_STAT, 32'h100);
      read_data($sformatf("pp%0d_second", k));
    end

    // Flush, then IRQ threshold
    send_frame(8'h11, 1'b0, 1'b0, 11);
    send_frame(8'h22, 1'b0, 1'b0, 11);
    read_check("preflush_status", A_STAT, 32'h200);
    axi_write(A_CTRL, 32'h4); tb_rx_en = 1'b0; sb_q.delete();
    read_check("flush_status", A_STAT, 32'h001);
    read_check("flush_ctrl", A_CTRL, 32'h0);
    axi_write(A_CTRL, 32'h3); tb_rx_en = 1'b1;
    axi_write(A_IRQ, 32'h3);
    read_check("irq_level", A_IRQ, 32'h3);
    send_frame(8'h31, 1'b0, 1'b0, 11);
    send_frame(8'h32, 1'b0, 1'b0, 11);
    intr_check("lvl3_two", 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 11);
    intr_check("lvl3_three", 1'b1);
    read_data("lvl_data0");
    read_data("lvl_data1");
    intr_check("lvl3_one", 1'b0);
    axi_write(A_IRQ, 32'h0);
    intr_check("lvl0_one", 1'b1);
    read_data("lvl_data2");
    intr_check("lvl0_empty", 1'b0);

    // Receiver disabled
    axi_write(A_CTRL, 32'h2); tb_rx_en = 1'b0;
    send_frame(8'h44, 1'b0, 1'b0, 11);
    read_check("rx_off_status", A_STAT, 32'h001);
    read_data("rx_off_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
- Second-generation PS/2 keyboard controller; AXI4-Lite slave on the peripheral bus.
- Receives device-to-host PS/2 frames and checks start, parity and stop bits.
- Buffers scancodes in a parametrised FIFO.
- Raises a level interrupt when at least IRQ_LEVEL codes are queued.
- Adds error flags, a frame watchdog and a flush command.

Parameters:
AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
AXI_ADDR_WIDTH, 16, AXI address width; decode uses addr[3:2]
FIFO_DEPTH, 16, scancode entries; power of two, 2..256
FILTER_LEN, 4, cycles ps2 lines must be stable before a change is accepted
TIMEOUT_CYC, 100000, max aclk cycles between falling ps2_clk edges inside a frame

Ports:
aclk  in  1  system clock
areset  in  1  asynchronous, active-high reset
ps2_clk  in  1  PS/2 clock line (async)
ps2_data  in  1  PS/2 data line (async)
kbd_intr  out  1  level interrupt
S_AXI_awaddr/awprot/awvalid/awready  in/in/in/out  AXI_ADDR_WIDTH/3/1/1  write address channel
S_AXI_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
S_AXI_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
S_AXI_araddr/arprot/arvalid/arready  in/in/in/out  AXI_ADDR_WIDTH/3/1/1  read address channel
S_AXI_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync release): all ready/valid outputs 0; bresp, rresp and rdata 0; kbd_intr 0; FIFO empty; error flags 0; CTRL=0; RX FSM in IDLE.
- Registers:
  - 0x0 DATA, RO: [7:0] head scancode, [8] valid. Reading while non-empty pops one entry. Reading while empty returns 0 with no pop.
  - 0x4 STATUS: [0] empty, [1] full, [2] overflow (W1C), [3] parity_err (W1C), [4] frame_err (W1C), [16:8] count.
  - 0x8 CTRL, RW: [0] rx_en, [1] irq_en, [2] flush (write-1 empties the FIFO; always reads 0).
  - 0xC IRQ_LEVEL, RW: [8:0] threshold; reset value 1; a value of 0 behaves as 1.
- AXI write:
  - awready and wready are asserted together for one cycle when awvalid and wvalid are both high and bvalid is 0.
  - The write takes effect on that edge, honouring wstrb.
  - bvalid rises the next cycle with bresp=OKAY and holds until bready.
- AXI read:
  - arready pulses when arvalid is high and rvalid is 0.
  - rdata is registered and rvalid rises the next cycle; rdata and rvalid hold stable until rready.
  - The DATA pop happens on the arready handshake.
  - rresp is always OKAY; unmapped offsets read 0.
- Input conditioning: 2-FF synchroniser, then a stability filter. The filtered level changes only after FILTER_LEN consecutive equal samples.
- A falling edge of filtered ps2_clk samples filtered ps2_data. Edges are ignored while rx_en=0; clearing rx_en mid-frame aborts the frame silently.
- RX FSM, one transition per falling edge:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, set frame_err.
  - DATA: shift in LSB-first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and odd parity over data+parity -> push the byte; parity bad -> set parity_err, no push; stop=0 -> set frame_err, no push. Always -> IDLE.
- Watchdog: in any state other than IDLE, TIMEOUT_CYC cycles without a falling edge -> IDLE and set frame_err.
- FIFO:
  - Push while full: the byte is dropped and overflow is set.
  - Push and pop in the same cycle: both occur, count unchanged; when empty, the pushed byte is not popped.
  - Flush has priority over a same-cycle push and pop.
  - count ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Error flags are sticky. A W1C write in the same cycle as a new set event leaves the flag set.
- kbd_intr = irq_en AND (count >= max(IRQ_LEVEL,1) OR any error flag). It is registered, so it follows its cause by 1 cycle.

Test Plan:
- Reset mid-frame: after 5 bits, assert areset -> all outputs 0, STATUS reads 0x001, next full frame 0x1C is received correctly.
- rx_en=1, irq_en=1; send frames 0x1C, 0xF0, 0x1C -> STATUS count=3, kbd_intr=1 one cycle after first push; three DATA reads return 0x11C, 0x1F0, 0x11C; fourth read returns 0x000 and kbd_intr drops.
- Send frame 0x5A with even parity -> parity_err=1, count=0; write STATUS 0x08 -> flag clears, kbd_intr=0.
- FIFO_DEPTH=4; send 5 frames 0x01..0x05 -> full=1, overflow=1; reads return 0x101..0x104, then empty.
- Stop ps2_clk after 4 bits for TIMEOUT_CYC+2 cycles -> frame_err=1, FSM in IDLE; next frame 0x29 received correctly.
- Push and DATA-read handshake in the same cycle with count=1 -> count stays 1; flush via CTRL=0x4 -> count=0, empty=1; IRQ_LEVEL=3 with 2 queued -> kbd_intr=0, third code -> kbd_intr=1.
